// File: rtl/collision_monitor.sv
// Collision monitor for a side-scrolling runner: tracks lives, invulnerability
// after a hit and game-over, evaluating only on frame_tick.
// Optional build macro COLLISION_MONITOR_SCORE_EN adds the cleared-obstacle
// score counter; without it the score output is tied to zero.
module collision_monitor #(
  parameter int unsigned PLAYER_X      = 100,
  parameter int unsigned PLAYER_W      = 16,
  parameter int unsigned OBS_W         = 16,
  parameter int unsigned OBS_H         = 32,
  parameter int unsigned LIVES         = 3,
  parameter int unsigned INVULN_FRAMES = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        start,
  input  logic [9:0]  jump_height,
  input  logic [9:0]  obs_x,
  input  logic        obs_valid,
  output logic        playing,
  output logic        invuln,
  output logic        game_over,
  output logic        hit,
  output logic [1:0]  lives,
  output logic [15:0] score
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PLAY   = 2'd1;
  localparam logic [1:0] ST_INVULN = 2'd2;
  localparam logic [1:0] ST_OVER   = 2'd3;

  // Geometry in 11 bits so edge sums cannot wrap.
  localparam logic [10:0] PLAYER_L = 11'(PLAYER_X);
  localparam logic [10:0] PLAYER_R = 11'(PLAYER_X + PLAYER_W);
  localparam logic [10:0] OBS_W11  = 11'(OBS_W);
  localparam logic [10:0] OBS_H11  = 11'(OBS_H);

  logic [1:0]  state_q, state_d;
  logic [1:0]  lives_q, lives_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        hit_d;
  logic [10:0] obs_l, obs_r;
  logic        overlap;

  // Obstacle/player bounding-box overlap, player must be below obstacle top.
  always_comb begin
    obs_l   = {1'b0, obs_x};
    obs_r   = obs_l + OBS_W11;
    overlap = obs_valid && (obs_l < PLAYER_R) && (obs_r > PLAYER_L) &&
              ({1'b0, jump_height} < OBS_H11);
  end

  // Game state machine; nothing moves without a frame tick.
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    cnt_d   = cnt_q;
    hit_d   = 1'b0;
    if (frame_tick) begin
      case (state_q)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            state_d = ST_PLAY;
            lives_d = 2'(LIVES);
            cnt_d   = 8'd0;
          end
        end
        ST_PLAY: begin
          if (overlap) begin
            hit_d   = 1'b1;
            lives_d = lives_q - 2'd1;
            if (lives_q == 2'd1) begin
              state_d = ST_OVER;
            end else begin
              state_d = ST_INVULN;
              cnt_d   = 8'(INVULN_FRAMES);
            end
          end
        end
        ST_INVULN: begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = ST_PLAY;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and registered status outputs decoded from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      lives_q   <= 2'd0;
      cnt_q     <= 8'd0;
      hit       <= 1'b0;
      playing   <= 1'b0;
      invuln    <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state_q   <= state_d;
      lives_q   <= lives_d;
      cnt_q     <= cnt_d;
      hit       <= hit_d;
      playing   <= (state_d == ST_PLAY) || (state_d == ST_INVULN);
      invuln    <= (state_d == ST_INVULN);
      game_over <= (state_d == ST_OVER);
    end
  end

  assign lives = lives_q;

`ifdef COLLISION_MONITOR_SCORE_EN
  logic [15:0] score_q, score_d;
  logic        passed_q, passed_d;
  logic        start_game, active, cleared, fresh;

  // Score an obstacle once when its right edge is at or left of the player.
  always_comb begin
    start_game = frame_tick && start && ((state_q == ST_IDLE) || (state_q == ST_OVER));
    active     = (state_q == ST_PLAY) || (state_q == ST_INVULN);
    cleared    = (obs_r <= PLAYER_L);
    fresh      = !obs_valid || (obs_l >= PLAYER_R);
    score_d    = score_q;
    passed_d   = passed_q;
    if (start_game) begin
      score_d  = 16'd0;
      passed_d = 1'b0;
    end else if (frame_tick && active) begin
      if (obs_valid && !passed_q && cleared) begin
        passed_d = 1'b1;
        if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
      end else if (fresh) begin
        passed_d = 1'b0;
      end
    end
  end

  // Score and pass-tracking registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      score_q  <= 16'd0;
      passed_q <= 1'b0;
    end else begin
      score_q  <= score_d;
      passed_q <= passed_d;
    end
  end

  assign score = score_q;
`else
  assign score = 16'd0;
`endif

endmodule

// File: tb/tb_collision_monitor.sv
// Scoreboard bench for collision_monitor: the driver advances a behavioural
// game model on every frame tick and queues the expected outputs; the monitor
// pops and compares after each tick and checks that nothing moves in between.
module tb_collision_monitor;

  localparam int PX = 100;
  localparam int PW = 16;
  localparam int OW = 16;
  localparam int OH = 32;
  localparam int NL = 3;
  localparam int NI = 60;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  jump_height = '0;
  logic [9:0]  obs_x = '0;
  logic        obs_valid = 1'b0;
  logic        playing, invuln, game_over, hit;
  logic [1:0]  lives;
  logic [15:0] score;

  collision_monitor #(
    .PLAYER_X(PX), .PLAYER_W(PW), .OBS_W(OW), .OBS_H(OH),
    .LIVES(NL), .INVULN_FRAMES(NI)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .jump_height(jump_height), .obs_x(obs_x), .obs_valid(obs_valid),
    .playing(playing), .invuln(invuln), .game_over(game_over), .hit(hit),
    .lives(lives), .score(score)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        playing;
    logic        invuln;
    logic        game_over;
    logic        hit;
    logic [1:0]  lives;
    logic [15:0] score;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp = '0;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Behavioural model: a running flag, frames of invulnerability left, counts.
  bit m_run, m_over, m_passed;
  int m_inv, m_lives, m_score;

  task automatic model_reset();
    m_run = 0; m_over = 0; m_passed = 0; m_inv = 0; m_lives = 0; m_score = 0;
  endtask

  function automatic exp_t model_out(bit h);
    exp_t e;
    e.playing   = m_run;
    e.invuln    = m_run && (m_inv > 0);
    e.game_over = m_over;
    e.hit       = h;
    e.lives     = 2'(m_lives);
`ifdef COLLISION_MONITOR_SCORE_EN
    e.score     = 16'(m_score);
`else
    e.score     = 16'd0;
`endif
    return e;
  endfunction

  task automatic model_tick(input bit st, input int jh, input int ox, input bit ov,
                            output bit h);
    bit ovl;
    ovl = ov && (ox < PX + PW) && (ox + OW > PX) && (jh < OH);
    h = 0;
    if (!m_run) begin
      if (st) begin
        m_run = 1; m_over = 0; m_lives = NL; m_score = 0; m_passed = 0; m_inv = 0;
      end
    end else begin
      if (m_inv > 0) begin
        m_inv--;
      end else if (ovl) begin
        h = 1;
        m_lives--;
        if (m_lives == 0) begin
          m_run = 0; m_over = 1;
        end else begin
          m_inv = NI;
        end
      end
      if (ov && !m_passed && (ox + OW <= PX)) begin
        m_passed = 1;
        if (m_score < 65535) m_score++;
      end else if (!ov || ox >= PX + PW) begin
        m_passed = 0;
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    chk({tag, " playing"},   int'(playing),   int'(e.playing));
    chk({tag, " invuln"},    int'(invuln),    int'(e.invuln));
    chk({tag, " game_over"}, int'(game_over), int'(e.game_over));
    chk({tag, " hit"},       int'(hit),       int'(e.hit));
    chk({tag, " lives"},     int'(lives),     int'(e.lives));
    chk({tag, " score"},     int'(score),     int'(e.score));
  endtask

  // Driver helpers.
  task automatic do_tick(input bit st, input int jh, input int ox, input bit ov);
    bit h;
    @(negedge clk);
    start = st; jump_height = 10'(jh); obs_x = 10'(ox); obs_valid = ov;
    frame_tick = 1'b1;
    model_tick(st, jh, ox, ov, h);
    exp_q.push_back(model_out(h));
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic idle_random(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      jump_height = 10'($urandom);
      obs_x = 10'($urandom);
      obs_valid = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Monitor: pop after each tick, otherwise outputs must hold with hit low.
  initial begin
    forever begin
      bit t;
      exp_t held;
      @(posedge clk);
      t = frame_tick && reset;
      @(negedge clk);
      if (!reset) continue;
      if (t) begin
        if (exp_q.size() == 0) begin
          chk("tick without expectation", 1, 0);
        end else begin
          last_exp = exp_q.pop_front();
          check_all("tick", last_exp);
        end
      end else begin
        held = last_exp;
        held.hit = 1'b0;
        check_all("hold", held);
      end
    end
  end

  // Asynchronous reset must clear everything without waiting for a clock.
  always @(negedge reset) begin
    #1;
    check_all("reset", '0);
    last_exp = '0;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    model_reset();
    #3 reset = 1'b0;
    #20 reset = 1'b1;

    // New game.
    do_tick(1, 0, 300, 0);
    // Hit, then invulnerability over 59 overlapping ticks, PLAY on the 60th.
    do_tick(0, 0, 100, 1);
    for (int i = 0; i < NI; i++) do_tick(0, 0, 100, 1);
    // Jump over, clear, then stay cleared.
    do_tick(0, 40, 100, 1);
    do_tick(0, 0, 80, 1);
    do_tick(0, 0, 70, 1);
    // Remaining lives lost with invulnerability between hits.
    do_tick(0, 0, 300, 0);
    do_tick(0, 0, 95, 1);
    for (int i = 0; i < NI; i++) do_tick(0, 0, 95, 1);
    do_tick(0, 0, 100, 1);
    do_tick(1, 0, 100, 1);
    // Restart from game over.
    do_tick(1, 0, 300, 0);
    do_tick(1, 0, 300, 0);
    // Overlap held without ticks: nothing may change.
    do_tick(0, 0, 100, 1);
    @(negedge clk);
    start = 1'b1; jump_height = 10'd0; obs_x = 10'd100; obs_valid = 1'b1;
    repeat (100) @(negedge clk);
    do_tick(0, 0, 100, 1);
    pulse_reset();
    do_tick(0, 0, 100, 1);
    do_tick(1, 0, 300, 0);

    // Randomized play.
    for (int n = 0; n < 1500; n++) begin
      bit st, ov;
      int jh, ox;
      st = ($urandom_range(0, 9) == 0);
      ov = ($urandom_range(0, 4) != 0);
      ox = $urandom_range(40, 160);
      jh = $urandom_range(0, 50);
      do_tick(st, jh, ox, ov);
      idle_random($urandom_range(0, 2));
      if ($urandom_range(0, 199) == 0) pulse_reset();
    end

    repeat (3) @(negedge clk);
    chk("queue drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
